page_bitmap_alloc: RTL and testbench
====================================

# page_bitmap_alloc

Single-cycle-issue page allocator that owns the 64-entry free/used bitmap of the MMU and drives the lowest-free-slot scanner feeding allocation results. It accepts one allocation request at a time (valid/ready), returns the 0-based index of the lowest free page or a failure indication, and accepts independent free requests every cycle. It sits between the MMU request front end and the page table/frame logic, and is the sole writer of the free bitmap.

## Interface
- RESV_PAGES, default 0: number of low pages (indices 0..RESV_PAGES-1) marked used at reset and never allocatable or freeable; legal range 0..63.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- alloc_req  input  1  allocation request; accepted only when alloc_ready=1.
- alloc_ready  output  1  high when the block can accept an allocation request.
- alloc_valid  output  1  one-cycle pulse: allocation succeeded, alloc_pos valid.
- alloc_fail  output  1  one-cycle pulse: no free page at scan time.
- alloc_pos  output  6  0-based allocated page index; held until next grant.
- free_req  input  1  free request, accepted every cycle.
- free_pos  input  6  0-based page index to free.
- free_err  output  1  one-cycle pulse: rejected free (see Configuration).
- free_cnt  output  7  number of free pages, 0..64.
- bitmap_out  output  64  current bitmap; bit i=1 means page i used.

## Operation
- Bitmap convention: 1 = used, 0 = free. Scanner finds lowest 0 bit.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: alloc_ready=1. alloc_req=1 -> SCAN; bitmap snapshot presented to scanner.
  - SCAN: alloc_ready=0; scanner registers one-hot mask, 1-based position (0 = none), found flag. -> COMMIT.
  - COMMIT: alloc_ready=0. If found: set bitmap bit (pos-1), alloc_pos<=pos-1, pulse alloc_valid, free_cnt decrements. Else pulse alloc_fail, bitmap unchanged. -> IDLE.
- Snapshot semantics: frees landing during SCAN do not change the scan result; a scan that found nothing still reports alloc_fail even if a page was freed meanwhile.
- Free: if bit free_pos is 1 and free_pos >= RESV_PAGES, clear it next edge, free_cnt increments. Otherwise no bitmap/count change (double free or reserved page).
- Simultaneous COMMIT set of bit p and free of bit q: q!=p both applied, free_cnt net unchanged; q==p is a double free (bit was 0 at edge) -> rejected, allocation still commits.
- free_cnt is a maintained counter, always equal to popcount of ~bitmap_out.
- Reset mid-operation: FSM returns to IDLE, any in-flight allocation dropped with no pulse.

## Timing
- Reset values: bitmap_out = low RESV_PAGES bits 1, rest 0; free_cnt = 64-RESV_PAGES; alloc_ready=1; alloc_valid=0; alloc_fail=0; alloc_pos=0; free_err=0.
- Alloc latency: request accepted at edge N; alloc_valid/alloc_fail high during cycle after edge N+2; alloc_ready low for cycles N+1..N+2, high again in cycle after N+2 (throughput one grant per 3 cycles).
- Free latency: bitmap_out and free_cnt reflect the free after one edge; free_err pulses in the same cycle as the update would.
- alloc_req while alloc_ready=0 is ignored; requester holds alloc_req until accepted.

## Configuration
- FREE_CHECK_EN defined: rejected frees (bit already 0, or free_pos < RESV_PAGES) pulse free_err for one cycle.
- Undefined: free_err tied 0; rejected frees still have no effect on bitmap or free_cnt.

## Structure
- Shared package: PAGE_NUM=64, PAGE_IDX_W=6, PAGE_CNT_W=7, FSM state enum (IDLE/SCAN/COMMIT), bitmap type.
- One sub-module: free_slot_scan — registered lowest-zero scanner (64-bit in; one-hot mask, 7-bit 1-based position, found flag out; 1-cycle latency, active-high sync reset).

## Test plan
- Reset with RESV_PAGES=2, single alloc -> alloc_valid, alloc_pos=2, bitmap_out=0x7, free_cnt=61.
- 64 back-to-back allocs from empty (RESV_PAGES=0) -> alloc_pos 0..63 in order, then 65th alloc -> alloc_fail, free_cnt=0.
- Full bitmap, free_pos=37, then alloc -> alloc_pos=37, free_cnt returns to 0.
- Free during SCAN of a full map -> alloc_fail still reported, free_cnt=1 afterwards, next alloc returns freed index.
- With FREE_CHECK_EN: free of free page 10 and free of reserved page 0 -> free_err pulses each, bitmap/free_cnt unchanged; without macro free_err stays 0.
- Assert rst during SCAN -> next cycle all outputs at reset values, no alloc_valid/alloc_fail pulse.

Source files
------------

// File: rtl/page_bitmap_alloc_pkg.sv
// Shared constants and types for the page bitmap allocator and its scanner.
package page_bitmap_alloc_pkg;

  localparam int PAGE_NUM   = 64;
  localparam int PAGE_IDX_W = 6;
  localparam int PAGE_CNT_W = 7;

  typedef logic [PAGE_NUM-1:0] bitmap_t;
  typedef logic [1:0]          fsm_state_t;

  localparam fsm_state_t IDLE   = 2'd0;
  localparam fsm_state_t SCAN   = 2'd1;
  localparam fsm_state_t COMMIT = 2'd2;

endpackage

// File: rtl/page_bitmap_alloc_free_slot_scan.sv
// Registered lowest-zero scanner: one-hot mask, 1-based position (0 = none)
// and found flag for the lowest free page, one cycle after the bitmap is seen.
module free_slot_scan
  import page_bitmap_alloc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  bitmap_t               vec_i,
  output bitmap_t               mask_o,
  output logic [PAGE_CNT_W-1:0] pos_o,
  output logic                  found_o
);

  bitmap_t               mask_d, mask_q;
  logic [PAGE_CNT_W-1:0] pos_d, pos_q;
  logic                  found_d, found_q;

  // Adding one ripples through the low run of ones, isolating the lowest zero.
  always_comb begin
    mask_d  = ~vec_i & (vec_i + bitmap_t'(1));
    found_d = ~&vec_i;
    pos_d   = '0;
    for (int i = PAGE_NUM - 1; i >= 0; i--) begin
      if (!vec_i[i]) pos_d = PAGE_CNT_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      pos_q   <= pos_d;
      found_q <= found_d;
    end
  end

  assign mask_o  = mask_q;
  assign pos_o   = pos_q;
  assign found_o = found_q;

endmodule

// File: rtl/page_bitmap_alloc.sv
// 64-page free/used bitmap allocator with an IDLE/SCAN/COMMIT issue FSM.
// Optional macro FREE_CHECK_EN enables the free_err pulse on rejected frees.
module page_bitmap_alloc
  import page_bitmap_alloc_pkg::*;
#(
  parameter int RESV_PAGES = 0
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic                  alloc_valid,
  output logic                  alloc_fail,
  output logic [PAGE_IDX_W-1:0] alloc_pos,
  input  logic                  free_req,
  input  logic [PAGE_IDX_W-1:0] free_pos,
  output logic                  free_err,
  output logic [PAGE_CNT_W-1:0] free_cnt,
  output logic [PAGE_NUM-1:0]   bitmap_out
);

  localparam bitmap_t               RESV_MASK = (64'd1 << RESV_PAGES) - 64'd1;
  localparam logic [PAGE_CNT_W-1:0] RESET_CNT = PAGE_CNT_W'(PAGE_NUM - RESV_PAGES);

  fsm_state_t            state_d, state_q;
  bitmap_t               bitmap_d, bitmap_q;
  logic [PAGE_CNT_W-1:0] cnt_d, cnt_q;
  logic [PAGE_IDX_W-1:0] pos_d, pos_q;
  logic                  valid_d, valid_q;
  logic                  fail_d, fail_q;

  bitmap_t               scan_mask;
  logic [PAGE_CNT_W-1:0] scan_pos;
  logic                  scan_found;

  logic                  free_ok;
  logic                  commit;
  logic                  alloc_ok;

  // The scanner samples the live bitmap at the SCAN->COMMIT edge, so a free
  // landing on that same edge is invisible to the result being committed.
  free_slot_scan u_scan (
    .clk     (clk),
    .rst     (rst),
    .vec_i   (bitmap_q),
    .mask_o  (scan_mask),
    .pos_o   (scan_pos),
    .found_o (scan_found)
  );

  // Reserved pages stay set forever, so the mask check is what rejects them.
  assign free_ok  = free_req && bitmap_q[free_pos] && !RESV_MASK[free_pos];
  assign commit   = (state_q == COMMIT);
  assign alloc_ok = commit && scan_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (alloc_req) state_d = SCAN;
      SCAN:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bitmap_d = bitmap_q;
    if (alloc_ok) bitmap_d = bitmap_d | scan_mask;
    if (free_ok)  bitmap_d[free_pos] = 1'b0;

    case ({alloc_ok, free_ok})
      2'b10:   cnt_d = cnt_q - PAGE_CNT_W'(1);
      2'b01:   cnt_d = cnt_q + PAGE_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    pos_d   = alloc_ok ? PAGE_IDX_W'(scan_pos - PAGE_CNT_W'(1)) : pos_q;
    valid_d = alloc_ok;
    fail_d  = commit && !scan_found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitmap_q <= RESV_MASK;
      cnt_q    <= RESET_CNT;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      fail_q   <= fail_d;
    end
  end

`ifdef FREE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= free_req && !free_ok;
  end

  assign free_err = err_q;
`else
  assign free_err = 1'b0;
`endif

  assign alloc_ready = (state_q == IDLE);
  assign alloc_valid = valid_q;
  assign alloc_fail  = fail_q;
  assign alloc_pos   = pos_q;
  assign free_cnt    = cnt_q;
  assign bitmap_out  = bitmap_q;

endmodule

// File: tb/tb_page_bitmap_alloc.sv
// Directed bench for page_bitmap_alloc: one instance with no reserved pages,
// one with two reserved pages; vector table plus hand-written corner sequences.
module tb_page_bitmap_alloc;

`ifdef FREE_CHECK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  typedef struct {
    bit          isAlloc;
    int          pos;
    logic        expValid;
    logic [5:0]  expPos;
    logic        expErr;
    logic [63:0] expBitmap;
    logic [6:0]  expCnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  allocReq, allocReady, allocValid, allocFail, freeReq, freeErr;
  logic [5:0]  allocPos [2];
  logic [5:0]  freePos  [2];
  logic [6:0]  freeCnt  [2];
  logic [63:0] bitmap   [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  page_bitmap_alloc #(.RESV_PAGES(0)) dut0 (
    .clk(clk), .rst(rst),
    .alloc_req(allocReq[0]), .alloc_ready(allocReady[0]),
    .alloc_valid(allocValid[0]), .alloc_fail(allocFail[0]), .alloc_pos(allocPos[0]),
    .free_req(freeReq[0]), .free_pos(freePos[0]), .free_err(freeErr[0]),
    .free_cnt(freeCnt[0]), .bitmap_out(bitmap[0])
  );

  page_bitmap_alloc #(.RESV_PAGES(2)) dut2 (
    .clk(clk), .rst(rst),
    .alloc_req(allocReq[1]), .alloc_ready(allocReady[1]),
    .alloc_valid(allocValid[1]), .alloc_fail(allocFail[1]), .alloc_pos(allocPos[1]),
    .free_req(freeReq[1]), .free_pos(freePos[1]), .free_err(freeErr[1]),
    .free_cnt(freeCnt[1]), .bitmap_out(bitmap[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One allocation with exact latency; optional free in the SCAN (1) or COMMIT (2) cycle.
  task automatic applyStimulus(input int d, input int freeAt, input logic [5:0] fpos,
                               output logic v, output logic f,
                               output logic [5:0] p, output logic e);
    int waitCycles = 0;
    while (!allocReady[d] && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("ready before request", 64'(allocReady[d]), 64'd1);
    allocReq[d] = 1'b1;
    @(negedge clk);
    allocReq[d] = 1'b0;
    checkOutput("ready low in scan", 64'(allocReady[d]), 64'd0);
    checkOutput("no pulse in scan", 64'({allocValid[d], allocFail[d]}), 64'd0);
    if (freeAt == 1) begin
      freeReq[d] = 1'b1;
      freePos[d] = fpos;
    end
    @(negedge clk);
    freeReq[d] = 1'b0;
    checkOutput("ready low in commit", 64'(allocReady[d]), 64'd0);
    checkOutput("no pulse in commit", 64'({allocValid[d], allocFail[d]}), 64'd0);
    if (freeAt == 2) begin
      freeReq[d] = 1'b1;
      freePos[d] = fpos;
    end
    @(negedge clk);
    freeReq[d] = 1'b0;
    v = allocValid[d];
    f = allocFail[d];
    p = allocPos[d];
    e = freeErr[d];
    checkOutput("ready back high", 64'(allocReady[d]), 64'd1);
  endtask

  task automatic applyFree(input int d, input int p, output logic e);
    freeReq[d] = 1'b1;
    freePos[d] = 6'(p);
    @(negedge clk);
    freeReq[d] = 1'b0;
    e = freeErr[d];
  endtask

  task automatic checkReset(input int d, input logic [63:0] expBitmap,
                            input logic [6:0] expCnt);
    checkOutput("reset bitmap", bitmap[d], expBitmap);
    checkOutput("reset free_cnt", 64'(freeCnt[d]), 64'(expCnt));
    checkOutput("reset ready", 64'(allocReady[d]), 64'd1);
    checkOutput("reset valid/fail", 64'({allocValid[d], allocFail[d]}), 64'd0);
    checkOutput("reset alloc_pos", 64'(allocPos[d]), 64'd0);
    checkOutput("reset free_err", 64'(freeErr[d]), 64'd0);
  endtask

  initial begin
    vec_t vecs[12];
    logic v, f, e;
    logic [5:0] p;

    vecs[0]  = '{1, 0,  1'b1, 6'd2, 1'b0, 64'h7,  7'd61};
    vecs[1]  = '{1, 0,  1'b1, 6'd3, 1'b0, 64'hF,  7'd60};
    vecs[2]  = '{1, 0,  1'b1, 6'd4, 1'b0, 64'h1F, 7'd59};
    vecs[3]  = '{0, 3,  1'b0, 6'd0, 1'b0, 64'h17, 7'd60};
    vecs[4]  = '{1, 0,  1'b1, 6'd3, 1'b0, 64'h1F, 7'd59};
    vecs[5]  = '{0, 10, 1'b0, 6'd0, ERR,  64'h1F, 7'd59};
    vecs[6]  = '{0, 0,  1'b0, 6'd0, ERR,  64'h1F, 7'd59};
    vecs[7]  = '{0, 1,  1'b0, 6'd0, ERR,  64'h1F, 7'd59};
    vecs[8]  = '{0, 4,  1'b0, 6'd0, 1'b0, 64'h0F, 7'd60};
    vecs[9]  = '{0, 2,  1'b0, 6'd0, 1'b0, 64'h0B, 7'd61};
    vecs[10] = '{1, 0,  1'b1, 6'd2, 1'b0, 64'h0F, 7'd60};
    vecs[11] = '{1, 0,  1'b1, 6'd4, 1'b0, 64'h1F, 7'd59};

    rst        = 1'b1;
    allocReq   = '0;
    freeReq    = '0;
    freePos[0] = '0;
    freePos[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkReset(0, 64'h0, 7'd64);
    checkReset(1, 64'h3, 7'd62);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].isAlloc) begin
        applyStimulus(1, 0, 6'd0, v, f, p, e);
        checkOutput($sformatf("vec%0d alloc_valid", i), 64'(v), 64'(vecs[i].expValid));
        checkOutput($sformatf("vec%0d alloc_fail", i), 64'(f), 64'(!vecs[i].expValid));
        checkOutput($sformatf("vec%0d alloc_pos", i), 64'(p), 64'(vecs[i].expPos));
      end else begin
        applyFree(1, vecs[i].pos, e);
      end
      checkOutput($sformatf("vec%0d free_err", i), 64'(e), 64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d bitmap", i), bitmap[1], vecs[i].expBitmap);
      checkOutput($sformatf("vec%0d free_cnt", i), 64'(freeCnt[1]), 64'(vecs[i].expCnt));
    end

    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 6'd0, v, f, p, e);
      checkOutput($sformatf("fill%0d valid", i), 64'({v, f}), 64'b10);
      checkOutput($sformatf("fill%0d pos", i), 64'(p), 64'(i));
    end
    applyStimulus(0, 0, 6'd0, v, f, p, e);
    checkOutput("full alloc valid/fail", 64'({v, f}), 64'b01);
    checkOutput("full alloc pos held", 64'(p), 64'd63);
    checkOutput("full free_cnt", 64'(freeCnt[0]), 64'd0);
    checkOutput("full bitmap", bitmap[0], '1);

    applyFree(0, 37, e);
    checkOutput("free37 cnt", 64'(freeCnt[0]), 64'd1);
    checkOutput("free37 bitmap", bitmap[0], ~(64'd1 << 37));
    checkOutput("free37 err", 64'(e), 64'd0);
    applyStimulus(0, 0, 6'd0, v, f, p, e);
    checkOutput("realloc37 valid", 64'({v, f}), 64'b10);
    checkOutput("realloc37 pos", 64'(p), 64'd37);
    checkOutput("realloc37 cnt", 64'(freeCnt[0]), 64'd0);

    applyStimulus(0, 1, 6'd20, v, f, p, e);
    checkOutput("free in scan fail", 64'({v, f}), 64'b01);
    checkOutput("free in scan cnt", 64'(freeCnt[0]), 64'd1);
    applyStimulus(0, 0, 6'd0, v, f, p, e);
    checkOutput("after scan free pos", 64'(p), 64'd20);
    checkOutput("after scan free cnt", 64'(freeCnt[0]), 64'd0);

    applyFree(0, 5, e);
    applyFree(0, 9, e);
    checkOutput("two frees cnt", 64'(freeCnt[0]), 64'd2);
    applyStimulus(0, 2, 6'd40, v, f, p, e);
    checkOutput("commit+free valid", 64'({v, f}), 64'b10);
    checkOutput("commit+free pos", 64'(p), 64'd5);
    checkOutput("commit+free err", 64'(e), 64'd0);
    checkOutput("commit+free cnt", 64'(freeCnt[0]), 64'd2);
    checkOutput("commit+free bitmap", bitmap[0], ~((64'd1 << 9) | (64'd1 << 40)));
    applyStimulus(0, 2, 6'd9, v, f, p, e);
    checkOutput("commit+same free valid", 64'({v, f}), 64'b10);
    checkOutput("commit+same free pos", 64'(p), 64'd9);
    checkOutput("commit+same free err", 64'(e), 64'(ERR));
    checkOutput("commit+same free cnt", 64'(freeCnt[0]), 64'd1);
    checkOutput("commit+same free bitmap", bitmap[0], ~(64'd1 << 40));

    allocReq[0] = 1'b1;
    @(negedge clk);
    allocReq[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset(0, 64'h0, 7'd64);
    checkReset(1, 64'h3, 7'd62);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("no pulse after reset %0d", i),
                  64'({allocValid[0], allocFail[0]}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
